// File: rtl/limn2600_cache_pkg.sv
// limn2600_cache_pkg: hash, widths and controller states shared by the cache
// controller and the data array, so both map an address to the same entry.
package limn2600_cache_pkg;
  localparam int ADDR_W = 32;
  localparam int DEF_ENTRIES = 1023;
  localparam int IDX_W = $clog2(DEF_ENTRIES);
  localparam int TAG_W = ADDR_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, FLUSH} state_e;
  // Folds high word-address bits onto low ones. The byte offset is shifted
  // out, so addresses in the same word always hash identically.
  function automatic logic [31:0] hash_result(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] w;
    w = addr >> 2;
    return w ^ (w >> 11) ^ (w >> 21);
  endfunction
endpackage

// File: rtl/limn2600_cache_tags.sv
// limn2600_cache_tags: tag RAM plus valid flops for the cache controller.
//   re_i/we_i/idx_i/tag_i : single read/write port; read data is registered
//   clr_i/clr_idx_i       : clears one valid bit (used by the flush walk)
//   rd_tag_o/rd_valid_o   : tag and valid of the last read index
module limn2600_cache_tags import limn2600_cache_pkg::*; #(
  parameter int N = DEF_ENTRIES,
  parameter int IW = IDX_W,
  parameter int TW = TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [TW-1:0] tag_i,
  input  logic          clr_i,
  input  logic [IW-1:0] clr_idx_i,
  output logic [TW-1:0] rd_tag_o,
  output logic          rd_valid_o
);
  logic [TW-1:0] tag_mem [N];
  logic [N-1:0] valid_q;
  // Tags carry no reset; the valid bits alone decide whether a tag means anything.
  always_ff @(posedge clk) begin
    if (we_i) tag_mem[idx_i] <= tag_i;
    if (re_i) rd_tag_o <= tag_mem[idx_i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      if (we_i) valid_q[idx_i] <= 1'b1;
      if (clr_i) valid_q[clr_idx_i] <= 1'b0;
      if (re_i) rd_valid_o <= valid_q[idx_i];
    end
  end
endmodule

// File: rtl/limn2600_cache_ctrl.sv
// limn2600_cache_ctrl: sequencing controller for the hashed direct-mapped
// instruction cache data array.
//   cpu_req_*  / cpu_resp_*  : fetch request in, one-cycle response pulse out
//   mem_req_*  / mem_resp_*  : miss fetch over a valid/ready read bus
//   cache_*                  : data array write port and read key/data
//   flush                    : pulse that invalidates every entry
module limn2600_cache_ctrl import limn2600_cache_pkg::*; #(
  parameter int NUM_ENTRIES = DEF_ENTRIES,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] cpu_resp_data,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr_in,
  output logic [DATA_WIDTH-1:0] cache_data_in,
  output logic [ADDR_WIDTH-1:0] cache_addr_out,
  input  logic [DATA_WIDTH-1:0] cache_data_out
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int TW = ADDR_WIDTH - 2;
  state_e state_q;
  logic [ADDR_WIDTH-1:0] addr_q, key;
  logic [IW-1:0] cnt_q, idx;
  logic [TW-1:0] rd_tag;
  logic pend_q, re, rd_valid, hit, go_flush;
  assign go_flush = pend_q || flush;
  // An incoming flush pulse drops ready in the same cycle so a request
  // presented alongside it is never considered accepted.
  assign cpu_req_ready = state_q == IDLE && !go_flush;
  assign re = cpu_req_valid && cpu_req_ready;
  // The one tag port serves lookups of the incoming address and the fill write.
  assign key = state_q == FILL ? addr_q : cpu_req_addr;
  assign idx = IW'(hash_result(key) % NUM_ENTRIES);
  // The data array is keyed by the raw request in IDLE so its registered read
  // lands in LOOKUP together with the tag.
  assign cache_addr_out = state_q == IDLE ? cpu_req_addr : addr_q;
  assign hit = rd_valid && rd_tag == addr_q[ADDR_WIDTH-1:2];
  limn2600_cache_tags #(.N(NUM_ENTRIES), .IW(IW), .TW(TW)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .re_i      (re),
    .we_i      (state_q == FILL),
    .idx_i     (idx),
    .tag_i     (addr_q[ADDR_WIDTH-1:2]),
    .clr_i     (state_q == FLUSH),
    .clr_idx_i (cnt_q),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_data <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      cache_we <= 1'b0;
      cache_addr_in <= '0;
      cache_data_in <= '0;
    end else begin
      cpu_resp_valid <= 1'b0;
      cache_we <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_flush) begin
            state_q <= FLUSH;
            pend_q <= 1'b0;
            cnt_q <= '0;
          end else if (cpu_req_valid) begin
            addr_q <= cpu_req_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_resp_data <= cache_data_out;
            state_q <= go_flush ? FLUSH : IDLE;
            pend_q <= 1'b0;
            cnt_q <= '0;
          end else begin
            pend_q <= go_flush;
            mem_req_valid <= 1'b1;
            mem_req_addr <= {addr_q[ADDR_WIDTH-1:2], 2'b00};
            state_q <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          pend_q <= go_flush;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          pend_q <= go_flush;
          if (mem_resp_valid) begin
            cache_we <= 1'b1;
            cache_addr_in <= addr_q;
            cache_data_in <= mem_resp_data;
            cpu_resp_valid <= 1'b1;
            cpu_resp_data <= mem_resp_data;
            state_q <= FILL;
          end
        end
        // Going straight to FLUSH keeps ready low for exactly the walk length.
        FILL: begin
          state_q <= go_flush ? FLUSH : IDLE;
          pend_q <= 1'b0;
          cnt_q <= '0;
        end
        // Flush pulses here are absorbed: the walk is never restarted.
        FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == IW'(NUM_ENTRIES - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// tb_limn2600_cache_ctrl: self-checking bench with a data array stub, a
// memory responder driven in-line and a per-index tag/valid reference model.
module tb_limn2600_cache_ctrl;
  import limn2600_cache_pkg::*;
  localparam int NE = 1023;
  logic clk = 0, rst = 1;
  logic cpu_req_valid = 0, cpu_req_ready, cpu_resp_valid, flush = 0;
  logic [31:0] cpu_req_addr = 0, cpu_resp_data;
  logic mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0;
  logic [31:0] mem_req_addr, mem_resp_data = 0;
  logic cache_we;
  logic [31:0] cache_addr_in, cache_data_in, cache_addr_out, cache_data_out;
  int n_chk = 0, n_fail = 0;
  bit mv [NE];
  logic [29:0] mt [NE];
  logic [31:0] arr [NE];
  logic [31:0] pool [8];
  logic [31:0] a_addr, b_addr;
  bit found;
  int n;

  always #5 clk = ~clk;

  limn2600_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .cache_we(cache_we), .cache_addr_in(cache_addr_in), .cache_data_in(cache_data_in),
    .cache_addr_out(cache_addr_out), .cache_data_out(cache_data_out)
  );

  function automatic int idx_of(input logic [31:0] a);
    return int'(hash_result(a) % NE);
  endfunction

  function automatic logic [31:0] memd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h1000) ? 32'hDEADBEEF : (w * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Data array stub: write by key, registered read by key.
  always @(posedge clk) begin
    if (cache_we) arr[idx_of(cache_addr_in)] <= cache_data_in;
    cache_data_out <= arr[idx_of(cache_addr_out)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NE; i++) mv[i] = 0;
  endtask

  task automatic count_flush(input string tag);
    int c;
    c = 0;
    while (!cpu_req_ready && c < 3000) begin
      c++;
      flush = (c == 500);
      @(negedge clk);
    end
    flush = 0;
    chk(tag, c, NE);
    clear_model();
  endtask

  // mode 0: plain fetch, 1: flush pulse during MISS_WAIT, 2: async reset during MISS_WAIT
  task automatic fetch(input logic [31:0] a, input int stall, input int dly, input int mode);
    int ix, w;
    logic exp_hit;
    logic [31:0] d;
    ix = idx_of(a);
    exp_hit = mv[ix] && mt[ix] == a[31:2];
    d = memd(a);
    w = 0;
    while (!cpu_req_ready && w < 1100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(w < 1100), 1);
    cpu_req_valid = 1;
    cpu_req_addr = a;
    @(negedge clk);
    cpu_req_valid = 0;
    chk("lookup_no_resp", cpu_resp_valid, 0);
    if (exp_hit) begin
      @(negedge clk);
      chk("hit_resp_valid", cpu_resp_valid, 1);
      chk("hit_data", cpu_resp_data, d);
      chk("hit_no_mem", mem_req_valid, 0);
      chk("hit_ready", cpu_req_ready, 1);
      return;
    end
    w = 0;
    while (!mem_req_valid && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk("miss_req_valid", mem_req_valid, 1);
    chk("miss_req_addr", mem_req_addr, {a[31:2], 2'b00});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, {a[31:2], 2'b00});
      chk("stall_no_resp", cpu_resp_valid, 0);
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("req_dropped", mem_req_valid, 0);
    if (mode == 2) begin
      #2 rst = 1;
      #1;
      chk("arst_ready", cpu_req_ready, 1);
      chk("arst_resp_valid", cpu_resp_valid, 0);
      chk("arst_resp_data", cpu_resp_data, 0);
      chk("arst_mem_valid", mem_req_valid, 0);
      chk("arst_mem_addr", mem_req_addr, 0);
      chk("arst_we", cache_we, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      mem_resp_valid = 1;
      mem_resp_data = d;
      @(negedge clk);
      mem_resp_valid = 0;
      chk("late_resp_ignored", cpu_resp_valid, 0);
      chk("late_resp_no_we", cache_we, 0);
      chk("late_resp_ready", cpu_req_ready, 1);
      clear_model();
      return;
    end
    for (int i = 0; i < dly; i++) begin
      chk("wait_no_resp", cpu_resp_valid, 0);
      flush = (mode == 1 && i == 0);
      @(negedge clk);
      flush = 0;
    end
    mem_resp_valid = 1;
    mem_resp_data = d;
    @(negedge clk);
    mem_resp_valid = 0;
    mem_resp_data = $urandom;
    chk("fill_we", cache_we, 1);
    chk("fill_addr", cache_addr_in, a);
    chk("fill_data", cache_data_in, d);
    chk("fill_resp_valid", cpu_resp_valid, 1);
    chk("fill_resp_data", cpu_resp_data, d);
    chk("fill_not_ready", cpu_req_ready, 0);
    mv[ix] = 1;
    mt[ix] = a[31:2];
    @(negedge clk);
    chk("resp_pulse_end", cpu_resp_valid, 0);
    if (mode == 1) count_flush("flush_after_miss_len");
    else chk("post_fill_ready", cpu_req_ready, 1);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_req_ready, 1);
    chk("rst_resp_valid", cpu_resp_valid, 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    chk("rst_we", cache_we, 0);
    chk("rst_cache_addr_in", cache_addr_in, 0);
    chk("rst_cache_data_in", cache_data_in, 0);
    chk("rst_cache_addr_out", cache_addr_out, 0);
    rst = 0;
    @(negedge clk);
    a_addr = 32'h1000;
    found = 0;
    b_addr = 0;
    for (int k = 1; k < 300000 && !found; k++) begin
      b_addr = a_addr + 32'(k) * 4;
      found = idx_of(b_addr) == idx_of(a_addr);
    end
    chk("alias_found", 32'(found), 1);
    fetch(a_addr, 0, 3, 0);
    fetch(a_addr, 0, 1, 0);
    fetch(b_addr, 1, 2, 0);
    fetch(a_addr, 0, 1, 0);
    fetch(32'h1002, 0, 1, 0);
    fetch(32'h2000, 10, 2, 0);
    fetch(32'h3000, 0, 3, 1);
    fetch(a_addr, 0, 1, 0);
    fetch(32'h4000, 0, 2, 2);
    fetch(32'h4000, 0, 2, 0);
    flush = 1;
    #1 chk("idle_flush_ready_drop", cpu_req_ready, 0);
    @(negedge clk);
    flush = 0;
    count_flush("idle_flush_len");
    pool[0] = a_addr;
    pool[1] = b_addr;
    pool[2] = 32'h2000;
    pool[3] = 32'h3000;
    for (int i = 4; i < 8; i++) pool[i] = $urandom & 32'hFFFF_FFFC;
    for (int i = 0; i < 40; i++)
      fetch(pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), $urandom_range(0, 3),
            $urandom_range(0, 4), ($urandom_range(0, 19) == 0) ? 1 : 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/limn2600_cache_ctrl.md
Name: limn2600_cache_ctrl

Overview:
Sequencing controller for the Limn2600 hashed direct-mapped instruction cache data array.
- Accepts CPU fetch requests and keeps a per-entry tag and valid store, because the data array itself has none.
- Decides hit or miss, fetches missed words from memory over a valid/ready handshake, writes them into the data array and returns data to the CPU.
- Sits between the fetch stage, the data array and the memory bus; also services whole-cache invalidation.

Parameters:
- NUM_ENTRIES, 1023: entry count; must equal the data array's NUM_ENTRIES.
- DATA_WIDTH, 32: word width.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cpu_req_valid  in  1  fetch request.
- cpu_req_addr  in  ADDR_WIDTH  fetch byte address; word-aligned, bits [1:0] ignored.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_resp_valid  out  1  one-cycle pulse with returned data.
- cpu_resp_data  out  DATA_WIDTH  returned word.
- flush  in  1  pulse: invalidate all entries.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  ADDR_WIDTH  word-aligned miss address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  memory data valid.
- mem_resp_data  in  DATA_WIDTH  memory data.
- cache_we  out  1  data array write enable.
- cache_addr_in  out  ADDR_WIDTH  data array write key.
- cache_data_in  out  DATA_WIDTH  data array write data.
- cache_addr_out  out  ADDR_WIDTH  data array read key.
- cache_data_out  in  DATA_WIDTH  data array registered read data.

Behaviour:
- Index = hash_result(addr) % NUM_ENTRIES. Use the identical hash as the data array, from the shared package. Tag = addr[ADDR_WIDTH-1:2], stored whole; no partial-tag compare.
- Storage:
  - Tag store: NUM_ENTRIES x (ADDR_WIDTH-2), no reset.
  - Valid store: NUM_ENTRIES flops, cleared asynchronously by rst.
- Reset:
  - State = IDLE.
  - All outputs 0 except cpu_req_ready = 1.
  - Valid bits cleared.
  - Pending flush cleared.
  - Reset mid-miss abandons the miss; a late mem_resp_valid arriving in IDLE is ignored.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, FLUSH.
- IDLE:
  - cpu_req_ready = 1 only in IDLE with no pending flush.
  - On valid&ready: latch the address, drive cache_addr_out = addr, read tag/valid registered, go to LOOKUP.
  - A pending or incoming flush takes priority over a new request: go to FLUSH, ready = 0.
- LOOKUP (one cycle; cache_data_out now valid):
  - Hit (valid & tag match): register cpu_resp_data = cache_data_out and pulse cpu_resp_valid next cycle, go to IDLE.
  - Hit latency is 2 clocks from the accepting edge to resp_valid high.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid = 1, mem_req_addr = {latched addr[31:2], 2'b00}, held stable until mem_req_ready.
  - On valid&ready go to MISS_WAIT.
- MISS_WAIT: on mem_resp_valid, capture data and go to FILL. A response in the same cycle as request acceptance is not permitted by the bus.
- FILL (one cycle):
  - cache_we = 1, cache_addr_in = latched addr, cache_data_in = captured data.
  - Write tag and set valid[index].
  - cpu_resp_valid pulse with the captured data; go to IDLE.
  - The evicted occupant of the same index is overwritten silently (read-only cache, no writeback).
- FLUSH:
  - Counter walks 0..NUM_ENTRIES-1, clearing one valid bit per cycle; NUM_ENTRIES cycles in total.
  - At the last index, return to IDLE.
  - flush asserted during FLUSH is absorbed (no restart).
- flush asserted in LOOKUP/MISS_*/FILL: latch a pending flag. The current request completes, then FLUSH runs before the next request is accepted.
- No response backpressure: the CPU must take cpu_resp_valid. At most one outstanding request.
- Data-array reads occur only in IDLE/LOOKUP. cache_addr_out holds the latched addr otherwise.

Decomposition:
- Package limn2600_cache_pkg: hash_result function, index width constant ($clog2(NUM_ENTRIES)), state enum, tag width constant. Shared with the data array so hashing cannot diverge.
- One sub-module, limn2600_cache_tags: tag RAM plus valid flop vector with async clear, single read/write port, clear-one-index port for flush.

Test Plan:
- Reset then cold fetch 0x00001000 -> MISS_REQ with mem_req_addr=0x00001000; memory returns 0xDEADBEEF after 3 cycles -> cache_we pulse, cpu_resp_data=0xDEADBEEF, ready back high.
- Same fetch 0x00001000 again -> no mem_req_valid, cpu_resp_valid exactly 2 clocks after accept with 0xDEADBEEF.
- Alias eviction:
  - Setup: two addresses with equal index, found with the package hash. Fill A, then B.
  - Check: refetch A misses.
  - Check: a fetch of 0x00001002 hits A's entry, since bits [1:0] are ignored.
- mem_req_ready held low 10 cycles -> mem_req_valid and mem_req_addr stable throughout, no response until handshake.
- flush asserted during MISS_WAIT:
  - Miss completes and returns data.
  - Then exactly NUM_ENTRIES (1023) cycles with cpu_req_ready=0.
  - Prior hit address now misses.
- rst asserted asynchronously in MISS_WAIT, then mem_resp_valid after release -> outputs at reset values, response ignored, next fetch of the same address misses.
